// File: rtl/ahb_pkg.sv
// Shared AHB bus types and burst-length helper for the bus arbiter.
package ahb_pkg;

  typedef enum logic [1:0] {
    TransIdle   = 2'b00,
    TransBusy   = 2'b01,
    TransNonseq = 2'b10,
    TransSeq    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    BurstSingle = 3'd0,
    BurstIncr   = 3'd1,
    BurstWrap4  = 3'd2,
    BurstIncr4  = 3'd3,
    BurstWrap8  = 3'd4,
    BurstIncr8  = 3'd5,
    BurstWrap16 = 3'd6,
    BurstIncr16 = 3'd7
  } hburst_e;

  typedef enum logic [2:0] {
    StIdle,
    StSingle,
    StBurst,
    StUndef,
    StLocked
  } arb_state_e;

  // Beats in a burst; undefined-length INCR reports 1 so its counter starts at 0.
  function automatic logic [4:0] burst_len(hburst_e burst);
    case (burst)
      BurstWrap4, BurstIncr4:   return 5'd4;
      BurstWrap8, BurstIncr8:   return 5'd8;
      BurstWrap16, BurstIncr16: return 5'd16;
      default:                  return 5'd1;
    endcase
  endfunction

endpackage

// File: rtl/ahb_arb_pick.sv
// Combinational winner selection: fixed priority (lowest index) by default,
// round-robin starting after ptr when AHB_ARB_RR_EN is defined.
module ahb_arb_pick
  import ahb_pkg::*;
#(
  parameter int unsigned NUM_MASTERS    = 4,
  parameter int unsigned DEFAULT_MASTER = 0
) (
`ifdef AHB_ARB_RR_EN
  input  logic [$clog2(NUM_MASTERS)-1:0] ptr,
`endif
  input  logic [NUM_MASTERS-1:0]         req,
  output logic [$clog2(NUM_MASTERS)-1:0] winner
);

  localparam int unsigned IW = $clog2(NUM_MASTERS);

`ifdef AHB_ARB_RR_EN
  logic [IW-1:0] idx;

  // Walk from the farthest candidate to the nearest so the one right after ptr wins.
  always_comb begin
    winner = IW'(DEFAULT_MASTER);
    idx    = '0;
    for (int unsigned k = NUM_MASTERS; k >= 1; k--) begin
      idx = IW'((32'(ptr) + k) % NUM_MASTERS);
      if (req[idx]) winner = idx;
    end
  end
`else
  always_comb begin
    winner = IW'(DEFAULT_MASTER);
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      if (req[i]) winner = IW'(i);
    end
  end
`endif

endmodule

// File: rtl/ahb_bus_arbiter.sv
// Multi-master AHB arbiter: burst-aware grant, owner and lock registers.
// Define AHB_ARB_RR_EN for round-robin arbitration; fixed priority otherwise.
module ahb_bus_arbiter
  import ahb_pkg::*;
#(
  parameter int unsigned NUM_MASTERS    = 4,
  parameter int unsigned DEFAULT_MASTER = 0
) (
  input  logic                           HCLK,
  input  logic                           HRESET,
  input  logic [NUM_MASTERS-1:0]         HBUSREQ,
  input  logic [NUM_MASTERS-1:0]         HLOCK,
  input  logic [1:0]                     HTRANS,
  input  logic [2:0]                     HBURST,
  input  logic                           HREADY,
  output logic [NUM_MASTERS-1:0]         HGRANT,
  output logic [$clog2(NUM_MASTERS)-1:0] HMASTER,
  output logic                           HMASTLOCK
);

  localparam int unsigned IW = $clog2(NUM_MASTERS);
  localparam logic [NUM_MASTERS-1:0] DefaultOh = NUM_MASTERS'(1) << DEFAULT_MASTER;

  htrans_e                trans;
  hburst_e                burst;
  arb_state_e             state_q, state_d;
  logic [4:0]             rem_q, rem_d;
  logic                   undef_q, undef_d;
  logic                   owner_lock, owner_req, arb_open;
  logic [IW-1:0]          winner, grant_idx;
  logic [NUM_MASTERS-1:0] winner_oh;

  assign trans      = htrans_e'(HTRANS);
  assign burst      = hburst_e'(HBURST);
  assign owner_lock = HLOCK[HMASTER];
  assign owner_req  = HBUSREQ[HMASTER];
  assign winner_oh  = NUM_MASTERS'(1) << winner;

`ifdef AHB_ARB_RR_EN
  logic [IW-1:0] ptr_q;
`endif

  ahb_arb_pick #(
    .NUM_MASTERS   (NUM_MASTERS),
    .DEFAULT_MASTER(DEFAULT_MASTER)
  ) u_pick (
`ifdef AHB_ARB_RR_EN
    .ptr   (ptr_q),
`endif
    .req   (HBUSREQ),
    .winner(winner)
  );

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (HGRANT[i]) grant_idx = IW'(i);
    end
  end

  // Counter and state as they will be after an HREADY-high edge. A NONSEQ or
  // IDLE while beats remain is an early termination and simply reloads/clears.
  always_comb begin
    rem_d   = rem_q;
    undef_d = undef_q;
    state_d = state_q;
    unique case (trans)
      TransNonseq: begin
        rem_d   = burst_len(burst) - 5'd1;
        undef_d = (burst == BurstIncr);
        if (owner_lock)                state_d = StLocked;
        else if (burst == BurstSingle) state_d = StSingle;
        else if (burst == BurstIncr)   state_d = StUndef;
        else                           state_d = StBurst;
      end
      TransSeq: begin
        if (rem_q != 5'd0) rem_d = rem_q - 5'd1;
      end
      TransIdle: begin
        rem_d   = 5'd0;
        undef_d = 1'b0;
        state_d = StIdle;
      end
      default: ;
    endcase
  end

  // Locked owners never release; BUSY inside a fixed burst never releases.
  assign arb_open = HREADY && !owner_lock &&
                    ((trans == TransIdle) ||
                     (state_q == StSingle) ||
                     (state_q == StBurst && trans != TransBusy && rem_d <= 5'd1) ||
                     (state_q == StUndef && undef_q && !owner_req));

  always_ff @(posedge HCLK) begin
    if (!HRESET) begin
      state_q   <= StIdle;
      rem_q     <= 5'd0;
      undef_q   <= 1'b0;
      HGRANT    <= DefaultOh;
      HMASTER   <= IW'(DEFAULT_MASTER);
      HMASTLOCK <= 1'b0;
`ifdef AHB_ARB_RR_EN
      ptr_q     <= IW'(DEFAULT_MASTER);
`endif
    end else if (HREADY) begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      undef_q   <= undef_d;
      HMASTER   <= grant_idx;
      HMASTLOCK <= HLOCK[grant_idx];
      if (arb_open) begin
        HGRANT <= winner_oh;
`ifdef AHB_ARB_RR_EN
        if (winner != grant_idx) ptr_q <= winner;
`endif
      end
    end
  end

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Scoreboard bench for ahb_bus_arbiter (4 masters, default master 0).
module tb_ahb_bus_arbiter;

  localparam int unsigned NM = 4;

  localparam logic [1:0] TI = 2'b00;
  localparam logic [1:0] TN = 2'b10;
  localparam logic [1:0] TS = 2'b11;
  localparam logic [2:0] BSINGLE = 3'd0;
  localparam logic [2:0] BINCR4  = 3'd3;
  localparam logic [2:0] BINCR8  = 3'd5;

  logic          HCLK = 1'b0;
  logic          HRESET;
  logic          HREADY;
  logic [NM-1:0] HBUSREQ;
  logic [NM-1:0] HLOCK;
  logic [1:0]    HTRANS;
  logic [2:0]    HBURST;
  logic [NM-1:0] HGRANT;
  logic [1:0]    HMASTER;
  logic          HMASTLOCK;

  typedef struct {
    string      tag;
    logic [3:0] grant;
    logic [1:0] master;
    logic       lock;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 HCLK = ~HCLK;

  ahb_bus_arbiter #(
    .NUM_MASTERS   (NM),
    .DEFAULT_MASTER(0)
  ) dut (
    .HCLK     (HCLK),
    .HRESET   (HRESET),
    .HBUSREQ  (HBUSREQ),
    .HLOCK    (HLOCK),
    .HTRANS   (HTRANS),
    .HBURST   (HBURST),
    .HREADY   (HREADY),
    .HGRANT   (HGRANT),
    .HMASTER  (HMASTER),
    .HMASTLOCK(HMASTLOCK)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, queue the expected post-edge outputs, then compare.
  task automatic step(input string tag, input logic rst_n, input logic rdy,
                      input logic [1:0] tr, input logic [2:0] bu,
                      input logic [3:0] req, input logic [3:0] lk,
                      input logic [3:0] eg, input logic [1:0] em, input logic el);
    exp_t e;
    HRESET  = rst_n;
    HREADY  = rdy;
    HTRANS  = tr;
    HBURST  = bu;
    HBUSREQ = req;
    HLOCK   = lk;
    e.tag    = tag;
    e.grant  = eg;
    e.master = em;
    e.lock   = el;
    sb_q.push_back(e);
    @(posedge HCLK);
    #1;
    e = sb_q.pop_front();
    check_eq({e.tag, ".grant"}, 32'(HGRANT), 32'(e.grant));
    check_eq({e.tag, ".master"}, 32'(HMASTER), 32'(e.master));
    check_eq({e.tag, ".lock"}, 32'(HMASTLOCK), 32'(e.lock));
  endtask

  initial begin
    logic [3:0] eg;
    logic [1:0] em;
    HRESET = 1'b0; HREADY = 1'b1; HTRANS = TI; HBURST = BSINGLE;
    HBUSREQ = '0; HLOCK = '0;

    // Reset and idle hold with no requests
    step("rst0", 1'b0, 1'b1, TI, BSINGLE, 4'b0000, 4'b0000, 4'b0001, 2'd0, 1'b0);
    step("rst1", 1'b0, 1'b1, TI, BSINGLE, 4'b0000, 4'b0000, 4'b0001, 2'd0, 1'b0);
    for (int i = 0; i < 10; i++)
      step("idle", 1'b1, 1'b1, TI, BSINGLE, 4'b0000, 4'b0000, 4'b0001, 2'd0, 1'b0);

    // Request on idle bus: grant after 1 edge, owner one edge later
    step("req2_g", 1'b1, 1'b1, TI, BSINGLE, 4'b0100, 4'b0000, 4'b0100, 2'd0, 1'b0);
    step("req2_m", 1'b1, 1'b1, TI, BSINGLE, 4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b0);

    // M1 takes the bus, runs INCR4 while M3 waits
    step("m1_g", 1'b1, 1'b1, TI, BSINGLE, 4'b0010, 4'b0000, 4'b0010, 2'd2, 1'b0);
    step("m1_m", 1'b1, 1'b1, TI, BSINGLE, 4'b0010, 4'b0000, 4'b0010, 2'd1, 1'b0);
    step("b4_1", 1'b1, 1'b1, TN, BINCR4, 4'b1000, 4'b0000, 4'b0010, 2'd1, 1'b0);
    step("b4_2", 1'b1, 1'b1, TS, BINCR4, 4'b1000, 4'b0000, 4'b0010, 2'd1, 1'b0);
    step("b4_3", 1'b1, 1'b1, TS, BINCR4, 4'b1000, 4'b0000, 4'b1000, 2'd1, 1'b0);
    step("b4_4", 1'b1, 1'b1, TS, BINCR4, 4'b1000, 4'b0000, 4'b1000, 2'd3, 1'b0);

    // Same burst with two wait states on beat 2
    step("m1b_g", 1'b1, 1'b1, TI, BSINGLE, 4'b0010, 4'b0000, 4'b0010, 2'd3, 1'b0);
    step("m1b_m", 1'b1, 1'b1, TI, BSINGLE, 4'b0010, 4'b0000, 4'b0010, 2'd1, 1'b0);
    step("w4_1", 1'b1, 1'b1, TN, BINCR4, 4'b1000, 4'b0000, 4'b0010, 2'd1, 1'b0);
    step("w4_ws0", 1'b1, 1'b0, TS, BINCR4, 4'b1000, 4'b0000, 4'b0010, 2'd1, 1'b0);
    step("w4_ws1", 1'b1, 1'b0, TS, BINCR4, 4'b1000, 4'b0000, 4'b0010, 2'd1, 1'b0);
    step("w4_2", 1'b1, 1'b1, TS, BINCR4, 4'b1000, 4'b0000, 4'b0010, 2'd1, 1'b0);
    step("w4_3", 1'b1, 1'b1, TS, BINCR4, 4'b1000, 4'b0000, 4'b1000, 2'd1, 1'b0);
    step("w4_4", 1'b1, 1'b1, TS, BINCR4, 4'b1000, 4'b0000, 4'b1000, 2'd3, 1'b0);

    // M0 holds a locked sequence of SINGLEs while M1 requests
    step("m0_g", 1'b1, 1'b1, TI, BSINGLE, 4'b0001, 4'b0000, 4'b0001, 2'd3, 1'b0);
    step("m0_m", 1'b1, 1'b1, TI, BSINGLE, 4'b0001, 4'b0000, 4'b0001, 2'd0, 1'b0);
    for (int i = 0; i < 3; i++)
      step("lk", 1'b1, 1'b1, TN, BSINGLE, 4'b0010, 4'b0001, 4'b0001, 2'd0, 1'b1);
    step("unlk_g", 1'b1, 1'b1, TI, BSINGLE, 4'b0010, 4'b0000, 4'b0010, 2'd0, 1'b0);
    step("unlk_m", 1'b1, 1'b1, TI, BSINGLE, 4'b0010, 4'b0000, 4'b0010, 2'd1, 1'b0);

    // All masters requesting on an idle bus
    step("rst2", 1'b0, 1'b1, TI, BSINGLE, 4'b1111, 4'b0000, 4'b0001, 2'd0, 1'b0);
    for (int i = 0; i < 5; i++) begin
`ifdef AHB_ARB_RR_EN
      eg = 4'b0001 << ((i + 1) % 4);
      em = 2'(i % 4);
`else
      eg = 4'b0001;
      em = 2'd0;
`endif
      step("arb", 1'b1, 1'b1, TI, BSINGLE, 4'b1111, 4'b0000, eg, em, 1'b0);
    end

    // Reset during beat 6 of an INCR8 owned by M2
    step("rst3", 1'b0, 1'b1, TI, BSINGLE, 4'b0000, 4'b0000, 4'b0001, 2'd0, 1'b0);
    step("m2_g", 1'b1, 1'b1, TI, BSINGLE, 4'b0100, 4'b0000, 4'b0100, 2'd0, 1'b0);
    step("m2_m", 1'b1, 1'b1, TI, BSINGLE, 4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b0);
    step("b8_1", 1'b1, 1'b1, TN, BINCR8, 4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b0);
    for (int i = 2; i <= 5; i++)
      step("b8_seq", 1'b1, 1'b1, TS, BINCR8, 4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b0);
    check_eq("b8_rem_mid", 32'(dut.rem_q), 32'd3);
    step("b8_rst", 1'b0, 1'b1, TS, BINCR8, 4'b0100, 4'b0000, 4'b0001, 2'd0, 1'b0);
    check_eq("b8_rem_rst", 32'(dut.rem_q), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
